// File: rtl/sequenciador_entrada.sv
// Push-button entry sequencer.
// A raw, bouncing button goes through a two-flop synchronizer and a debouncer.
// Each accepted press produces a one-cycle entrada_botao pulse. The pulse
// advances a four-step entry stage: A, B, op, execute. ciclo_completo marks
// the cycle in which the stage wraps back to A. The cancelar input returns
// the sequence to stage A without disturbing the button front end.
module sequenciador_entrada #(
    parameter int DEBOUNCE_CICLOS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       botao_bruto,
    input  logic       cancelar,
    output logic [1:0] contador_entrada,
    output logic       entrada_botao,
    output logic       ciclo_completo
);

    // Counter value at which a differing level has persisted long enough.
    localparam logic [7:0] LIMITE_DEBOUNCE = 8'(DEBOUNCE_CICLOS - 1);

    // Stage encoding as seen by the downstream decoder.
    localparam logic [1:0] ESTAGIO_A       = 2'b00;
    localparam logic [1:0] ESTAGIO_EXECUTA = 2'b11;

    // Next entry stage, wrapping from execute back to A.
    function automatic logic [1:0] proximo_estagio(input logic [1:0] estagio);
        proximo_estagio = estagio + 2'b01;
    endfunction

    // True when the stage about to be left is the last one of the sequence.
    function automatic logic fecha_ciclo(input logic [1:0] estagio);
        fecha_ciclo = (estagio == ESTAGIO_EXECUTA);
    endfunction

    // ------------------------------------------------------------------
    // Synchronizer: botao_meta may go metastable; only botao_sinc is used.
    // ------------------------------------------------------------------
    logic botao_meta;
    logic botao_sinc;

    // Two-flop synchronizer for the asynchronous button level.
    always_ff @(posedge clk) begin
        if (reset) begin
            botao_meta <= 1'b0;
            botao_sinc <= 1'b0;
        end else begin
            botao_meta <= botao_bruto;
            botao_sinc <= botao_meta;
        end
    end

    // ------------------------------------------------------------------
    // Debouncer: a changed level must persist DEBOUNCE_CICLOS cycles.
    // ------------------------------------------------------------------
    logic       botao_estavel;
    logic [7:0] contador_debounce;
    logic       nivel_difere;
    logic       nivel_aceito;
    logic       subida_aceita;

    assign nivel_difere  = (botao_sinc != botao_estavel);
    assign nivel_aceito  = nivel_difere && (contador_debounce == LIMITE_DEBOUNCE);
    assign subida_aceita = nivel_aceito && botao_sinc;

    // Debounce counter and stable level; any return to the stable level
    // discards the partial count, so short glitches never get through.
    always_ff @(posedge clk) begin
        if (reset) begin
            botao_estavel     <= 1'b0;
            contador_debounce <= 8'd0;
        end else if (!nivel_difere) begin
            contador_debounce <= 8'd0;
        end else if (nivel_aceito) begin
            botao_estavel     <= botao_sinc;
            contador_debounce <= 8'd0;
        end else begin
            contador_debounce <= contador_debounce + 8'd1;
        end
    end

    // ------------------------------------------------------------------
    // Entry stage: pulse on accepted rising level, advance when it ends.
    // ------------------------------------------------------------------

    // Press pulse, stage counter and wrap marker. cancelar overrides both
    // the increment and any pulse that would start at the same edge, so a
    // press coinciding with an abort is dropped rather than deferred.
    always_ff @(posedge clk) begin
        if (reset) begin
            contador_entrada <= ESTAGIO_A;
            entrada_botao    <= 1'b0;
            ciclo_completo   <= 1'b0;
        end else if (cancelar) begin
            contador_entrada <= ESTAGIO_A;
            entrada_botao    <= 1'b0;
            ciclo_completo   <= 1'b0;
        end else begin
            entrada_botao  <= subida_aceita;
            ciclo_completo <= entrada_botao && fecha_ciclo(contador_entrada);
            if (entrada_botao) begin
                contador_entrada <= proximo_estagio(contador_entrada);
            end
        end
    end

endmodule
